warp_issue_arbiter: RTL
=======================

// Module: warp_issue_arbiter
// PURPOSE
//   Picks one warp per cycle from the per-warp instruction-buffer heads and
//   forwards it through a single registered issue slot to the backend.
//   Sits between the frontend ibuf outputs (valid/ready per warp) and decode/issue.
//   Masks warps stalled by the scoreboard and supports per-warp flush.
// PARAMETERS
//   NUM_WARPS    8   number of warps / ibuf heads (power of 2, >=2)
//   PAYLOAD_BITS 128 per-warp packed instruction fields (pc, op, regs, imm, tmask, ...)
//   MAX_GREEDY   4   consecutive-grant limit under WARP_ARB_GTO_EN (>=1)
//   WARP_ID_BITS $clog2(NUM_WARPS) (localparam)
// PORTS
//   clock          in  1                      clock
//   reset          in  1                      reset, synchronous, active-high
//   ibuf_valid     in  NUM_WARPS              ibuf head valid, bit w = warp w
//   ibuf_ready     out NUM_WARPS              one-hot pop of the granted ibuf head
//   ibuf_payload   in  NUM_WARPS*PAYLOAD_BITS warp w at [w*PAYLOAD_BITS +: PAYLOAD_BITS]
//   warp_stall     in  NUM_WARPS              scoreboard/barrier stall, 1 = ineligible
//   flush_valid    in  1                      flush request
//   flush_wid      in  WARP_ID_BITS           warp to flush
//   issue_valid    out 1                      issue slot occupied
//   issue_ready    in  1                      backend accepts slot
//   issue_wid      out WARP_ID_BITS           warp id of slot
//   issue_payload  out PAYLOAD_BITS           payload of slot
//   issue_count    out 32                     total issue fires since reset, wraps at 2^32
// BEHAVIOUR
//   Reset: issue_valid=0, issue_wid=0, issue_payload=0, issue_count=0, rr_ptr=NUM_WARPS-1,
//     greedy_cnt=0; ibuf_ready=0 while reset is high.
//   eligible = ibuf_valid & ~warp_stall & ~(flush_valid ? onehot(flush_wid) : 0).
//   fire = issue_valid & issue_ready. can_load = ~issue_valid | fire.
//   Grant (combinational): if can_load & |eligible, choose one warp g; ibuf_ready = onehot(g),
//     else ibuf_ready=0. ibuf_ready never depends on issue_valid of the same warp elsewhere.
//   Round-robin: search order rr_ptr+1, rr_ptr+2, ... mod NUM_WARPS; first eligible wins.
//     On grant rr_ptr <= g. rr_ptr unchanged when nothing granted.
//   Load: on grant, slot <= {g, ibuf_payload[g]}, issue_valid <= 1 next cycle (latency 1
//     from ibuf handshake to issue_valid). Back-to-back: fire and grant in same cycle
//     replaces slot, issue_valid stays 1 -> full throughput, 1 issue/cycle.
//   fire without grant: issue_valid <= 0. issue_count increments on every fire.
//   Slot holds stable (wid, payload) while issue_valid & ~issue_ready (valid never drops
//     except by flush).
//   Flush: flush_valid & issue_valid & issue_wid==flush_wid & ~issue_ready -> issue_valid <= 0
//     next cycle (slot dropped, not counted). If fire in same cycle, fire wins (counted,
//     backend already owns it). Flushed warp is never granted in the flush cycle; other
//     warps may be granted if can_load (slot freed by flush reloads from next cycle).
//   Stall changes take effect in the same cycle (combinational mask); a stalled warp
//     already in the slot is not recalled.
//   Reset mid-operation: slot dropped, pointers/counter return to reset values.
// CONFIGURATION
//   WARP_ARB_GTO_EN defined: greedy-then-oldest. If rr_ptr warp is eligible and
//     greedy_cnt < MAX_GREEDY, it is granted again and greedy_cnt++; otherwise fall back
//     to round-robin from rr_ptr+1 and greedy_cnt <= 1 on grant of a different warp.
//     Flush of the greedy warp resets greedy_cnt to 0.
//   Not defined: pure round-robin as above; greedy_cnt absent.
// TESTING (NUM_WARPS=4, MAX_GREEDY=2)
//   After reset, ibuf_valid=4'b1111, issue_ready=1 -> ibuf_ready 0001,0010,0100,1000,0001;
//     issue_wid 0,1,2,3 one cycle later; issue_count=4 after 4 fires.
//   ibuf_valid=4'b1010, warp_stall=4'b1000 -> only warp 1 granted; drop stall -> 3 then 1.
//   issue_ready=0 for 5 cycles with slot=warp 2 -> ibuf_ready=0, wid/payload stable, count
//     unchanged; issue_ready=1 -> fire and new grant same cycle, issue_valid stays 1.
//   Slot=warp 3, issue_ready=0, flush_valid=1 flush_wid=3, ibuf_valid=4'b1001 -> next cycle
//     issue_valid=0, warp 3 not granted in flush cycle; count unchanged.
//   flush_wid=slot wid with issue_ready=1 -> fire counted (count+1), no drop.
//   WARP_ARB_GTO_EN, ibuf_valid=4'b0011 steady -> grant sequence 0,0,1,1,0,0.

Source files
------------

// File: rtl/warp_issue_arbiter.sv
// Warp issue arbiter: picks one eligible ibuf head per cycle into a single registered issue slot.
// Define WARP_ARB_GTO_EN for greedy-then-oldest selection; default is pure round-robin.
module warp_issue_arbiter #(
  parameter int unsigned NUM_WARPS    = 8,
  parameter int unsigned PAYLOAD_BITS = 128,
  parameter int unsigned MAX_GREEDY   = 4,
  localparam int unsigned WARP_ID_BITS = $clog2(NUM_WARPS)
) (
  input  logic                              clock,
  input  logic                              reset,
  input  logic [NUM_WARPS-1:0]              ibuf_valid,
  output logic [NUM_WARPS-1:0]              ibuf_ready,
  input  logic [NUM_WARPS*PAYLOAD_BITS-1:0] ibuf_payload,
  input  logic [NUM_WARPS-1:0]              warp_stall,
  input  logic                              flush_valid,
  input  logic [WARP_ID_BITS-1:0]           flush_wid,
  output logic                              issue_valid,
  input  logic                              issue_ready,
  output logic [WARP_ID_BITS-1:0]           issue_wid,
  output logic [PAYLOAD_BITS-1:0]           issue_payload,
  output logic [31:0]                       issue_count
);

  if ((NUM_WARPS < 2) || ((NUM_WARPS & (NUM_WARPS - 1)) != 0)) begin : g_chk_warps
    $error("NUM_WARPS must be a power of 2 and >= 2");
  end
  if (MAX_GREEDY < 1) begin : g_chk_greedy
    $error("MAX_GREEDY must be >= 1");
  end

  logic [NUM_WARPS-1:0]    flush_mask;
  logic [NUM_WARPS-1:0]    eligible;
  logic                    fire;
  logic                    can_load;
  logic                    load;
  logic                    flush_hit;
  logic [WARP_ID_BITS-1:0] rr_ptr;
  logic [WARP_ID_BITS-1:0] rr_pick;
  logic                    rr_found;
  logic [WARP_ID_BITS-1:0] grant_wid;
  logic                    grant_any;
  logic [PAYLOAD_BITS-1:0] payload_arr [NUM_WARPS];

  always_comb begin
    flush_mask = '0;
    if (flush_valid) flush_mask[flush_wid] = 1'b1;
  end

  always_comb begin
    eligible  = ibuf_valid & ~warp_stall & ~flush_mask;
    fire      = issue_valid & issue_ready;
    can_load  = ~issue_valid | fire;
    flush_hit = flush_valid & issue_valid & (issue_wid == flush_wid) & ~issue_ready;
  end

  always_comb begin
    for (int unsigned w = 0; w < NUM_WARPS; w++) begin
      payload_arr[w] = ibuf_payload[w*PAYLOAD_BITS +: PAYLOAD_BITS];
    end
  end

  // Search rr_ptr+1 .. rr_ptr+NUM_WARPS; the index wraps naturally in WARP_ID_BITS.
  always_comb begin
    rr_found = 1'b0;
    rr_pick  = '0;
    for (int unsigned i = 1; i <= NUM_WARPS; i++) begin
      if (!rr_found && eligible[rr_ptr + WARP_ID_BITS'(i)]) begin
        rr_found = 1'b1;
        rr_pick  = rr_ptr + WARP_ID_BITS'(i);
      end
    end
  end

`ifdef WARP_ARB_GTO_EN
  localparam int unsigned GCNT_BITS = $clog2(MAX_GREEDY + 1);

  logic [GCNT_BITS-1:0] greedy_cnt;
  logic                 greedy_hit;

  always_comb begin
    greedy_hit = eligible[rr_ptr] && (greedy_cnt < GCNT_BITS'(MAX_GREEDY));
    grant_wid  = greedy_hit ? rr_ptr : rr_pick;
    grant_any  = greedy_hit | rr_found;
  end

  // A fallback grant starts a fresh burst even if it lands on the same warp.
  always_ff @(posedge clock) begin
    if (reset) begin
      greedy_cnt <= '0;
    end else if (load) begin
      greedy_cnt <= greedy_hit ? greedy_cnt + GCNT_BITS'(1) : GCNT_BITS'(1);
    end else if (flush_valid && (flush_wid == rr_ptr)) begin
      greedy_cnt <= '0;
    end
  end
`else
  always_comb begin
    grant_wid = rr_pick;
    grant_any = rr_found;
  end
`endif

  always_comb begin
    load       = can_load & grant_any;
    ibuf_ready = '0;
    if (load && !reset) ibuf_ready[grant_wid] = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      issue_valid   <= 1'b0;
      issue_wid     <= '0;
      issue_payload <= '0;
      issue_count   <= '0;
      rr_ptr        <= WARP_ID_BITS'(NUM_WARPS - 1);
    end else begin
      if (fire) issue_count <= issue_count + 32'd1;
      if (load) begin
        issue_valid   <= 1'b1;
        issue_wid     <= grant_wid;
        issue_payload <= payload_arr[grant_wid];
        rr_ptr        <= grant_wid;
      end else if (fire || flush_hit) begin
        issue_valid <= 1'b0;
      end
    end
  end

endmodule
